seq_pattern_gen: RTL
====================

# seq_pattern_gen

Parametrised serial pattern generator: a programmable-length bit pattern is played out on one output, one bit per divided-clock step. Supports a run-time pattern load, run-time length, one-shot or looping playback, start/stop control and status flags. Generalises the fixed 12-step, fixed-pattern signal generator. Sits between the board clock and an indicator, buzzer or test-stimulus pin.

## Interface
- DIV, 250000: clocks per step; legal range ≥ 2.
- LEN, 12: pattern register width and maximum steps; legal range 2..32.
- SW, $clog2(LEN): step index width.

- iCLK  in  1  system clock; all logic on rising edge.
- iRST  in  1  reset, asynchronous, active-high.
- iSTART  in  1  start pulse; sampled in IDLE only.
- iSTOP  in  1  abort; highest priority after reset.
- iLOOP  in  1  playback mode, latched at start: 1 = loop, 0 = one-shot.
- iLAST  in  SW  index of the last step, latched at start; values > LEN-1 are clamped to LEN-1.
- iLOAD  in  1  pattern write strobe; honoured in IDLE only.
- iPAT  in  LEN  pattern data; bit n is the output for step n.
- oSIG  out  1  registered pattern output.
- oSTEP  out  SW  current step index.
- oBUSY  out  1  high in RUN.
- oDONE  out  1  one-clock pulse at the end of a one-shot.

## Operation
- Internal registers:
  - rPAT[LEN-1:0]
  - rLAST[SW-1:0]
  - rLOOP
  - divider rDIV, 0..DIV-1, width $clog2(DIV)
  - step counter rSTEP
  - state
- States are IDLE and RUN.
- Priority on each edge, highest first: iRST, then iSTOP, then iLOAD, then iSTART.
- IDLE:
  - rDIV = 0, oSIG = 0, oBUSY = 0.
  - iLOAD=1: rPAT ← iPAT. iSTART is ignored in the same cycle.
  - iSTART=1 with iLOAD=0 and iSTOP=0:
    - rLAST ← clamp(iLAST), rLOOP ← iLOOP, rSTEP ← 0, rDIV ← 0.
    - oSIG ← rPAT[0], state ← RUN.
- RUN:
  - rDIV increments every clock.
  - When rDIV == DIV-1 (the step tick), rDIV ← 0 and:
    - rSTEP < rLAST: rSTEP ← rSTEP+1, oSIG ← rPAT[rSTEP+1].
    - rSTEP == rLAST and rLOOP=1: rSTEP ← 0, oSIG ← rPAT[0].
    - rSTEP == rLAST and rLOOP=0: state ← IDLE, rSTEP ← 0, oSIG ← 0, oDONE ← 1 for one clock.
  - iSTART, iLOAD, iLOOP and iLAST are ignored in RUN.
  - iSTOP=1: next edge goes to IDLE with oSIG=0, rSTEP=0, rDIV=0. No oDONE is generated.
- iLAST=0 is legal: a one-step pattern. In loop mode, oSIG holds rPAT[0] indefinitely.
- Reset values:
  - oSIG=0, oSTEP=0, oBUSY=0, oDONE=0.
  - rPAT=0, rLAST=LEN-1, rLOOP=0, rDIV=0, state IDLE.

## Timing
- Start latency: iSTART high at edge k means oBUSY=1 and oSIG=rPAT[0] are valid after edge k.
- Each step lasts exactly DIV clocks, so the step-n output is held for edges k .. k+DIV-1 relative to its entry edge.
- One-shot duration: (rLAST+1)·DIV clocks from the start edge to the edge at which oBUSY falls and oDONE=1.
- oDONE is coincident with oBUSY falling and clears on the next edge.
- Loop wrap has no gap: step rLAST is followed directly by step 0 with no idle clock.
- iRST asserted mid-run clears all outputs immediately, asynchronously.
- iRST deasserting has no effect until the first rising edge after release.
- iSTOP and a step tick on the same edge: the stop wins and oDONE stays 0.
- oSIG and oSTEP are registered; there is no combinational path from inputs to outputs.

## Configuration
- SEQGEN_DEFAULT_PATTERN_EN defined: reset loads rPAT with 12'h688 (step sequence 0,0,0,1,0,0,0,1,0,1,1,0), zero-extended or truncated to LEN. It also sets rLAST=min(11,LEN-1), rLOOP=1 and state RUN, with oBUSY=1 and oSIG=0 (that is, rPAT[0]). Playback starts autonomously after reset, for legacy board builds.
- SEQGEN_DEFAULT_PATTERN_EN undefined: reset values are as listed under Operation and the block idles until iSTART.

## Test plan
All scenarios use DIV=4, LEN=8 unless noted.

- Load and one-shot: iLOAD with iPAT=8'b1010_0110, then iSTART with iLAST=7 and iLOOP=0.
  - oSIG sequence, 4 clocks per step: 0,1,1,0,0,1,0,1.
  - oDONE pulses once, 32 clocks after start.
  - oBUSY then falls.
- Loop and clamp: iSTART with iLAST=2, iLOOP=1, rPAT=8'b0000_0101.
  - oSTEP cycles 0,1,2,0,…; oSIG cycles 1,0,1,1,0,1,… with no gap and no oDONE.
  - Repeat with iLAST=7 on LEN=6: rLAST clamps to 5.
- Stop mid-run: assert iSTOP at step 3, clock 2.
  - Next edge: oBUSY=0, oSIG=0, oSTEP=0, oDONE never asserts.
  - Then assert iSTOP on a tick edge of the final step: oDONE stays 0.
- Ignored controls: iLOAD or iSTART during RUN leave rPAT and the sequence unchanged. iLOAD and iSTART together in IDLE load the pattern and do not start.
- Async reset mid-run: assert iRST between clock edges. All outputs go to 0 before the next edge, and playback needs a fresh iSTART after release.
- Macro build with SEQGEN_DEFAULT_PATTERN_EN defined, DIV=4, LEN=12:
  - After reset, oSIG loops 0,0,0,1,0,0,0,1,0,1,1,0 with a 48-clock period and oBUSY=1.

Source files
------------

// File: rtl/seq_pattern_gen.sv
// Serial pattern generator: plays rPAT bit n on oSIG during step n, each step lasting DIV clocks, one-shot or looping.
// Build option SEQGEN_DEFAULT_PATTERN_EN: reset preloads the legacy 12-step pattern and starts looping on its own.
module seq_pattern_gen #(
    parameter int DIV = 250000,
    parameter int LEN = 12,
    parameter int SW  = $clog2(LEN)
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          iSTART,
    input  logic          iSTOP,
    input  logic          iLOOP,
    input  logic [SW-1:0] iLAST,
    input  logic          iLOAD,
    input  logic [LEN-1:0] iPAT,
    output logic          oSIG,
    output logic [SW-1:0] oSTEP,
    output logic          oBUSY,
    output logic          oDONE
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam int            DW       = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX  = DW'(DIV - 1);
    localparam logic [DW-1:0] DIV_ONE  = DW'(1);
    localparam logic [SW-1:0] STEP_ONE = SW'(1);
    localparam logic [SW-1:0] LAST_MAX = SW'(LEN - 1);

`ifdef SEQGEN_DEFAULT_PATTERN_EN
    localparam logic [LEN-1:0] PAT_RST   = LEN'(12'h688);
    localparam logic [SW-1:0]  LAST_RST  = (LEN - 1 < 11) ? LAST_MAX : SW'(11);
    localparam logic           LOOP_RST  = 1'b1;
    localparam state_t         STATE_RST = S_RUN;
    localparam logic           SIG_RST   = PAT_RST[0];
`else
    localparam logic [LEN-1:0] PAT_RST   = '0;
    localparam logic [SW-1:0]  LAST_RST  = LAST_MAX;
    localparam logic           LOOP_RST  = 1'b0;
    localparam state_t         STATE_RST = S_IDLE;
    localparam logic           SIG_RST   = 1'b0;
`endif

    state_t         state_q, state_d;
    logic [LEN-1:0] pat_q,   pat_d;
    logic [SW-1:0]  last_q,  last_d;
    logic           loop_q,  loop_d;
    logic [DW-1:0]  div_q,   div_d;
    logic [SW-1:0]  step_q,  step_d;
    logic           sig_q,   sig_d;
    logic           done_q,  done_d;

    logic [SW-1:0]  last_clamp;
    logic [SW-1:0]  step_inc;
    logic           step_tick;
    logic           at_last;

    // Clamp only exists when the index field can encode values beyond the pattern.
    if (LEN < (1 << SW)) begin : g_clamp
        assign last_clamp = (iLAST > LAST_MAX) ? LAST_MAX : iLAST;
    end else begin : g_noclamp
        assign last_clamp = iLAST;
    end

    assign step_inc  = step_q + STEP_ONE;
    assign step_tick = (div_q == DIV_MAX);
    assign at_last   = (step_q == last_q);

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        last_d  = last_q;
        loop_d  = loop_q;
        div_d   = div_q;
        step_d  = step_q;
        sig_d   = sig_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                div_d  = '0;
                step_d = '0;
                sig_d  = 1'b0;
                if (iSTOP) begin
                    state_d = S_IDLE;
                end else if (iLOAD) begin
                    pat_d = iPAT;
                end else if (iSTART) begin
                    last_d  = last_clamp;
                    loop_d  = iLOOP;
                    sig_d   = pat_q[0];
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                if (iSTOP) begin
                    // Abort: no completion pulse, even if this edge was a step tick.
                    state_d = S_IDLE;
                    div_d   = '0;
                    step_d  = '0;
                    sig_d   = 1'b0;
                end else if (!step_tick) begin
                    div_d = div_q + DIV_ONE;
                end else begin
                    div_d = '0;
                    if (!at_last) begin
                        step_d = step_inc;
                        sig_d  = pat_q[step_inc];
                    end else if (loop_q) begin
                        step_d = '0;
                        sig_d  = pat_q[0];
                    end else begin
                        state_d = S_IDLE;
                        step_d  = '0;
                        sig_d   = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
                div_d   = '0;
                step_d  = '0;
                sig_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q <= STATE_RST;
            pat_q   <= PAT_RST;
            last_q  <= LAST_RST;
            loop_q  <= LOOP_RST;
            div_q   <= '0;
            step_q  <= '0;
            sig_q   <= SIG_RST;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            last_q  <= last_d;
            loop_q  <= loop_d;
            div_q   <= div_d;
            step_q  <= step_d;
            sig_q   <= sig_d;
            done_q  <= done_d;
        end
    end

    assign oSIG  = sig_q;
    assign oSTEP = step_q;
    assign oBUSY = (state_q == S_RUN);
    assign oDONE = done_q;

endmodule
